window_extrema_seq: RTL and testbench

- Sequencer that drives two instances of the team's 16-bit unsigned magnitude comparator (gt/lt/eq outputs) to find the maximum and minimum of a window of WIN_LEN samples.
- Samples arrive one per accepted valid/ready handshake; results are registered and flagged with a one-cycle done pulse.
- Sits between a sample source (ADC/FIFO front end) and downstream consumers needing per-window peak data.

---
 rtl/window_extrema_seq.sv | 161 ++++++++++++++++
 tb/tb_window_extrema_seq.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/window_extrema_seq.sv
// Windowed max/min finder: an FSM accepts WIN_LEN samples over valid/ready and
// feeds two extrema lanes, each built around a 16-bit magnitude comparator.

module mag_cmp16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        gt,
  output logic        lt,
  output logic        eq
);
  assign gt = (a > b);
  assign lt = (a < b);
  assign eq = (a == b);
endmodule

// One extremum tracker; IS_MAX selects a running max (update on gt) or min (on lt).
module extrema_lane #(
  parameter bit IS_MAX = 1'b1,
  parameter int IDX_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_first,
  input  logic             acc_en,
  input  logic [15:0]      sample,
  input  logic [IDX_W-1:0] cur_idx,
  output logic [15:0]      val,
  output logic [IDX_W-1:0] idx
);
  localparam logic [15:0] RST_VAL = IS_MAX ? 16'h0000 : 16'hFFFF;

  logic [15:0]      val_q, val_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             gt, lt, eq, upd;

  mag_cmp16 u_cmp (.a(sample), .b(val_q), .gt(gt), .lt(lt), .eq(eq));

  // Ties never win, so the first occurrence's index is retained.
  assign upd = (IS_MAX ? gt : lt) & ~eq;

  always_comb begin
    val_d = val_q;
    idx_d = idx_q;
    if (load_first) begin
      val_d = sample;
      idx_d = '0;
    end else if (acc_en && upd) begin
      val_d = sample;
      idx_d = cur_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      val_q <= RST_VAL;
      idx_q <= '0;
    end else begin
      val_q <= val_d;
      idx_q <= idx_d;
    end
  end

  assign val = val_q;
  assign idx = idx_q;
endmodule

module window_extrema_seq #(
  parameter int WIN_LEN = 8,
  parameter int IDX_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sample_valid,
  input  logic [15:0]      sample,
  output logic             sample_ready,
  output logic             busy,
  output logic             done,
  output logic [15:0]      max_out,
  output logic [15:0]      min_out,
  output logic [IDX_W-1:0] max_idx,
  output logic [IDX_W-1:0] min_idx
);
  localparam int NUM_LANES = 2;  // lane 0 = max, lane 1 = min
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIN_LEN - 1);

  typedef enum logic [1:0] {IDLE, FIRST, ACCUM, DONE} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] count_q, count_d;
  logic             accept, load_first, acc_en;

  logic [NUM_LANES-1:0][15:0]      lane_val;
  logic [NUM_LANES-1:0][IDX_W-1:0] lane_idx;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  assign accept     = sample_valid & sample_ready;
  assign load_first = accept & (state_q == FIRST);
  assign acc_en     = accept & (state_q == ACCUM);

  // Next-state
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      IDLE:  if (start) state_d = FIRST;
      FIRST: if (accept) begin
        count_d = IDX_W'(1);
        state_d = (WIN_LEN == 1) ? DONE : ACCUM;
      end
      ACCUM: if (accept) begin
        count_d = count_q + IDX_W'(1);
        if (count_q == LAST_IDX) state_d = DONE;
      end
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: pure decodes of the registered state
  always_comb begin
    sample_ready = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    case (state_q)
      IDLE:    busy = 1'b0;
      FIRST,
      ACCUM:   sample_ready = 1'b1;
      DONE:    done = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    extrema_lane #(.IS_MAX(g == 0), .IDX_W(IDX_W)) u_lane (
      .clk       (clk),
      .rst       (rst),
      .load_first(load_first),
      .acc_en    (acc_en),
      .sample    (sample),
      .cur_idx   (count_q),
      .val       (lane_val[g]),
      .idx       (lane_idx[g])
    );
  end

  assign max_out = lane_val[0];
  assign max_idx = lane_idx[0];
  assign min_out = lane_val[1];
  assign min_idx = lane_idx[1];
endmodule

// File: tb/tb_window_extrema_seq.sv
// Directed bench for window_extrema_seq (WIN_LEN=8) with immediate-assertion checks.

module tb_window_extrema_seq;
  localparam int WIN_LEN = 8;
  localparam int IDX_W   = 16;

  logic             clk = 1'b0;
  logic             rst, start, sample_valid;
  logic [15:0]      sample;
  logic             sample_ready, busy, done;
  logic [15:0]      max_out, min_out;
  logic [IDX_W-1:0] max_idx, min_idx;

  int checks   = 0;
  int failures = 0;

  window_extrema_seq #(.WIN_LEN(WIN_LEN), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst), .start(start), .sample_valid(sample_valid),
    .sample(sample), .sample_ready(sample_ready), .busy(busy), .done(done),
    .max_out(max_out), .min_out(min_out), .max_idx(max_idx), .min_idx(min_idx)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_res(input string tag, input logic [15:0] mx, input logic [15:0] mxi,
                         input logic [15:0] mn, input logic [15:0] mni);
    chk({tag, ".max"},     32'(max_out), 32'(mx));
    chk({tag, ".max_idx"}, 32'(max_idx), 32'(mxi));
    chk({tag, ".min"},     32'(min_out), 32'(mn));
    chk({tag, ".min_idx"}, 32'(min_idx), 32'(mni));
  endtask

  // Start a window and feed 8 samples, with 'gap' idle-valid cycles after each.
  // start_at >= 0 raises start during the accept of that sample index.
  task automatic run_window(input string tag, input logic [15:0] v [8], input int gap,
                            input int start_at);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, ".ready_first"}, 32'(sample_ready), 32'd1);
    for (int i = 0; i < WIN_LEN; i++) begin
      sample_valid = 1'b1;
      sample       = v[i];
      start        = (i == start_at);
      tick();
      start        = 1'b0;
      sample_valid = 1'b0;
      if (i < WIN_LEN - 1) begin
        chk({tag, ".no_early_done"}, 32'(done), 32'd0);
        for (int g = 0; g < gap; g++) begin
          sample = 16'hDEAD;
          chk({tag, ".ready_gap"}, 32'(sample_ready), 32'd1);
          tick();
        end
      end
    end
    chk({tag, ".done"}, 32'(done), 32'd1);
  endtask

  initial begin
    logic [15:0] basic [8] = '{16'd5, 16'd3, 16'd9, 16'd1, 16'd9, 16'd7, 16'd1, 16'd4};
    logic [15:0] ext   [8] = '{16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000,
                               16'h8000, 16'h8000, 16'h8000, 16'h8000};
    logic [15:0] flat  [8] = '{8{16'd42}};
    int          done_cyc [$];
    int          cyc;

    rst = 1'b1; start = 1'b0; sample_valid = 1'b0; sample = '0;

    // Reset then idle
    tick(); tick();
    rst = 1'b0;
    chk("rst.ready", 32'(sample_ready), 32'd0);
    chk("rst.busy",  32'(busy),         32'd0);
    chk("rst.done",  32'(done),         32'd0);
    chk_res("rst", 16'h0000, 16'd0, 16'hFFFF, 16'd0);
    tick();
    chk("idle.busy", 32'(busy), 32'd0);

    // Basic back-to-back window
    run_window("basic", basic, 0, -1);
    chk_res("basic", 16'd9, 16'd2, 16'd1, 16'd3);
    tick();
    chk("basic.done_pulse", 32'(done), 32'd0);
    chk("basic.idle",       32'(busy), 32'd0);
    chk_res("basic.hold", 16'd9, 16'd2, 16'd1, 16'd3);

    // Same data with 3-cycle stalls
    run_window("stall", basic, 3, -1);
    chk_res("stall", 16'd9, 16'd2, 16'd1, 16'd3);
    tick();

    // Extremes and ties
    run_window("ext", ext, 0, -1);
    chk_res("ext", 16'hFFFF, 16'd0, 16'h0000, 16'd1);
    tick();

    // Reset mid-window
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sample_valid = 1'b1; sample = 16'(100 + i); tick();
    end
    sample_valid = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    chk("midrst.done", 32'(done), 32'd0);
    chk("midrst.busy", 32'(busy), 32'd0);
    chk_res("midrst", 16'h0000, 16'd0, 16'hFFFF, 16'd0);
    tick();
    chk("midrst.no_done", 32'(done), 32'd0);
    run_window("flat", flat, 0, -1);
    chk_res("flat", 16'd42, 16'd0, 16'd42, 16'd0);
    tick();

    // start pulsed while accumulating is ignored
    run_window("busystart", basic, 0, 3);
    chk_res("busystart", 16'd9, 16'd2, 16'd1, 16'd3);
    tick();
    chk("busystart.idle", 32'(busy), 32'd0);
    tick();
    chk("busystart.stay_idle", 32'(busy), 32'd0);

    // start held high, valid continuous: two windows back to back
    start = 1'b1; sample_valid = 1'b1; sample = 16'd0; cyc = 0;
    while (done_cyc.size() < 2 && cyc < 60) begin
      tick();
      cyc++;
      if (done) done_cyc.push_back(cyc);
      sample = 16'(cyc * 3);
    end
    start = 1'b0; sample_valid = 1'b0;
    chk("b2b.two_dones", 32'(done_cyc.size()), 32'd2);
    if (done_cyc.size() == 2) begin
      chk("b2b.spacing", 32'(done_cyc[1] - done_cyc[0]), 32'(WIN_LEN + 2));
      // Increasing data: max is the last accepted sample, min the first
      chk("b2b.max_idx", 32'(max_idx), 32'd7);
      chk("b2b.min_idx", 32'(min_idx), 32'd0);
    end
    tick();
    tick();
    chk("b2b.end_idle", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
